ascii_stream_validator: RTL and testbench

- Successor to the payload validator in the ASCII number-separation path. Sits between uart_packet_handler and the number parser.
- Validates and stores one packet payload in an internal RAM instead of a flat array port; downstream reads it through a registered read port.
- New over the previous generation:
  - parametrised depth and character-set options;
  - overflow detection;
  - first-error position/char capture;
  - token counting;
  - backpressure once done.

---
 rtl/ascii_num_sep_pkg.sv | 33 +++
 rtl/ascii_char_ram.sv | 33 +++
 rtl/ascii_stream_validator.sv | 126 ++++++++++++
 tb/tb_ascii_stream_validator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ascii_num_sep_pkg.sv
// Shared types, character constants and byte-classification helpers for the
// ASCII number-separation path.
package ascii_num_sep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_PLUS  = 8'h2B;
    localparam logic [7:0] CHAR_DOT   = 8'h2E;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_9     = 8'h39;

    function automatic logic is_terminator(input logic [7:0] ch);
        return (ch == CHAR_LF) || (ch == CHAR_CR);
    endfunction

    function automatic logic is_valid_char(input logic [7:0] ch,
                                           input logic       allow_plus,
                                           input logic       allow_decimal);
        return ((ch >= CHAR_0) && (ch <= CHAR_9)) ||
               (ch == CHAR_SPACE) || (ch == CHAR_MINUS) ||
               (allow_plus && (ch == CHAR_PLUS)) ||
               (allow_decimal && (ch == CHAR_DOT));
    endfunction

endpackage

// File: rtl/ascii_char_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the previous contents.
module ascii_char_ram #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rd_clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is cleared; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ascii_stream_validator.sv
// Validates one ASCII payload packet, stores it in internal RAM and reports
// length, token count, overflow and the first invalid character.
module ascii_stream_validator
    import ascii_num_sep_pkg::*;
#(
    parameter int MAX_PAYLOAD   = 2048,
    parameter int ALLOW_PLUS    = 0,
    parameter int ALLOW_DECIMAL = 0,
    parameter int NL_AS_SEP     = 0,
    localparam int ADDR_W       = $clog2(MAX_PAYLOAD),
    localparam int LEN_W        = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        payload_data,
    input  logic              payload_valid,
    input  logic              payload_last,
    output logic              payload_ready,
    input  logic              clear,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [LEN_W-1:0]  buffer_length,
    output logic [LEN_W-1:0]  token_count,
    output logic              done,
    output logic              invalid,
    output logic              overflow,
    output logic [LEN_W-1:0]  err_index,
    output logic [7:0]        err_char
);

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_PAYLOAD);

    state_t            state, state_next;
    logic [LEN_W-1:0]  wp;
    logic              prev_sep;
    logic              restart;
    logic              beat;
    logic              term;
    logic              store_try;
    logic              full;
    logic              we;
    logic              bad;
    logic [7:0]        wr_data;

    always_comb begin
        restart       = rst || clear;
        payload_ready = (state != DONE);
        beat          = payload_valid && payload_ready && !clear;
        term          = is_terminator(payload_data);
        store_try     = beat && (!term || (NL_AS_SEP != 0));
        full          = (wp == FULL_LEN);
        we            = store_try && !full;
        bad           = beat && !term &&
                        !is_valid_char(payload_data, ALLOW_PLUS != 0, ALLOW_DECIMAL != 0);
        wr_data       = term ? CHAR_SPACE : payload_data;
    end

    always_comb begin
        state_next = state;
        if (beat) begin
            if (payload_last) begin
                state_next = DONE;
            end else if (state == IDLE) begin
                state_next = COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // prev_sep starts at 1 so the first stored non-separator opens a token.
    always_ff @(posedge clk) begin
        if (restart) begin
            wp          <= '0;
            prev_sep    <= 1'b1;
            token_count <= '0;
            invalid     <= 1'b0;
            overflow    <= 1'b0;
            err_index   <= '0;
            err_char    <= '0;
        end else begin
            if (we) begin
                wp <= wp + 1'b1;
                if (wr_data == CHAR_SPACE) begin
                    prev_sep <= 1'b1;
                end else begin
                    prev_sep <= 1'b0;
                    if (prev_sep) begin
                        token_count <= token_count + 1'b1;
                    end
                end
            end
            if (store_try && full) begin
                overflow <= 1'b1;
            end
            if (bad && !invalid) begin
                invalid   <= 1'b1;
                err_index <= wp;
                err_char  <= payload_data;
            end
        end
    end

    assign buffer_length = wp;
    assign done          = (state == DONE);

    ascii_char_ram #(
        .DEPTH  (MAX_PAYLOAD),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rd_clr  (restart),
        .we      (we),
        .wr_addr (wp[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ascii_stream_validator.sv
// Table-driven bench: four validator configurations share one stimulus stream;
// each record checks the outputs of one selected configuration.
module tb_ascii_stream_validator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic        payload_last;
    logic        clear;
    logic [10:0] rd_addr;

    // instance 0: defaults, 1: MAX_PAYLOAD=8, 2: NL_AS_SEP=1, 3: ALLOW_DECIMAL=1
    logic        rdy0, rdy1, rdy2, rdy3;
    logic [7:0]  rd0, rd1, rd2, rd3;
    logic [11:0] len0, tok0, eix0, len2, tok2, eix2, len3, tok3, eix3;
    logic [3:0]  len1, tok1, eix1;
    logic        dn0, dn1, dn2, dn3, inv0, inv1, inv2, inv3, ov0, ov1, ov2, ov3;
    logic [7:0]  ech0, ech1, ech2, ech3;

    always #5 clk = ~clk;

    ascii_stream_validator u0 (
        .clk(clk), .rst(rst), .payload_data(payload_data), .payload_valid(payload_valid),
        .payload_last(payload_last), .payload_ready(rdy0), .clear(clear), .rd_addr(rd_addr),
        .rd_data(rd0), .buffer_length(len0), .token_count(tok0), .done(dn0), .invalid(inv0),
        .overflow(ov0), .err_index(eix0), .err_char(ech0));

    ascii_stream_validator #(.MAX_PAYLOAD(8)) u1 (
        .clk(clk), .rst(rst), .payload_data(payload_data), .payload_valid(payload_valid),
        .payload_last(payload_last), .payload_ready(rdy1), .clear(clear), .rd_addr(rd_addr[2:0]),
        .rd_data(rd1), .buffer_length(len1), .token_count(tok1), .done(dn1), .invalid(inv1),
        .overflow(ov1), .err_index(eix1), .err_char(ech1));

    ascii_stream_validator #(.NL_AS_SEP(1)) u2 (
        .clk(clk), .rst(rst), .payload_data(payload_data), .payload_valid(payload_valid),
        .payload_last(payload_last), .payload_ready(rdy2), .clear(clear), .rd_addr(rd_addr),
        .rd_data(rd2), .buffer_length(len2), .token_count(tok2), .done(dn2), .invalid(inv2),
        .overflow(ov2), .err_index(eix2), .err_char(ech2));

    ascii_stream_validator #(.ALLOW_DECIMAL(1)) u3 (
        .clk(clk), .rst(rst), .payload_data(payload_data), .payload_valid(payload_valid),
        .payload_last(payload_last), .payload_ready(rdy3), .clear(clear), .rd_addr(rd_addr),
        .rd_data(rd3), .buffer_length(len3), .token_count(tok3), .done(dn3), .invalid(inv3),
        .overflow(ov3), .err_index(eix3), .err_char(ech3));

    int unsigned o_len [4], o_tok [4], o_eix [4], o_ech [4], o_rd [4];
    logic        o_rdy [4], o_dn [4], o_inv [4], o_ov [4];

    always_comb begin
        o_len[0] = 32'(len0); o_len[1] = 32'(len1); o_len[2] = 32'(len2); o_len[3] = 32'(len3);
        o_tok[0] = 32'(tok0); o_tok[1] = 32'(tok1); o_tok[2] = 32'(tok2); o_tok[3] = 32'(tok3);
        o_eix[0] = 32'(eix0); o_eix[1] = 32'(eix1); o_eix[2] = 32'(eix2); o_eix[3] = 32'(eix3);
        o_ech[0] = 32'(ech0); o_ech[1] = 32'(ech1); o_ech[2] = 32'(ech2); o_ech[3] = 32'(ech3);
        o_rd[0]  = 32'(rd0);  o_rd[1]  = 32'(rd1);  o_rd[2]  = 32'(rd2);  o_rd[3]  = 32'(rd3);
        o_rdy[0] = rdy0; o_rdy[1] = rdy1; o_rdy[2] = rdy2; o_rdy[3] = rdy3;
        o_dn[0]  = dn0;  o_dn[1]  = dn1;  o_dn[2]  = dn2;  o_dn[3]  = dn3;
        o_inv[0] = inv0; o_inv[1] = inv1; o_inv[2] = inv2; o_inv[3] = inv3;
        o_ov[0]  = ov0;  o_ov[1]  = ov1;  o_ov[2]  = ov2;  o_ov[3]  = ov3;
    end

    typedef struct {
        logic [127:0] data;
        int           n;
        int           inst;
        int           exp_len;
        int           exp_tok;
        int           exp_inv;
        int           exp_ov;
        int           exp_eix;
        int           exp_ech;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_clear();
        payload_valid = 1'b0;
        payload_last  = 1'b0;
        clear         = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // Bytes are taken from the most significant end of the right-justified literal.
    task automatic send_packet(input logic [127:0] d, input int n, input logic with_last);
        for (int i = 0; i < n; i++) begin
            payload_data  = d[8*(n-1-i) +: 8];
            payload_valid = 1'b1;
            payload_last  = with_last && (i == n - 1);
            @(posedge clk); #1;
        end
        payload_valid = 1'b0;
        payload_last  = 1'b0;
    endtask

    task automatic read_check(input string nm, input int inst, input int addr, input int exp);
        rd_addr = 11'(addr);
        @(posedge clk); #1;
        check(nm, o_rd[inst], exp);
    endtask

    initial begin
        logic [127:0] s;

        vecs[0] = '{"12 -3 45\n",  9, 0, 8,  3, 0, 0, 0, 8'h00};
        vecs[1] = '{"1a2b",        4, 0, 4,  1, 1, 0, 1, 8'h61};
        vecs[2] = '{"7777777777", 10, 1, 8,  1, 0, 1, 0, 8'h00};
        vecs[3] = '{"7777777777", 10, 0, 10, 1, 0, 0, 0, 8'h00};
        vecs[4] = '{"77777777a",   9, 1, 8,  1, 1, 1, 8, 8'h61};
        vecs[5] = '{"1\r\n2",      4, 2, 4,  2, 0, 0, 0, 8'h00};
        vecs[6] = '{"1\r\n2",      4, 0, 2,  1, 0, 0, 0, 8'h00};
        vecs[7] = '{"\n",          1, 0, 0,  0, 0, 0, 0, 8'h00};
        vecs[8] = '{"1.5+2",       5, 3, 5,  1, 1, 0, 3, 8'h2B};
        vecs[9] = '{"1.5+2",       5, 0, 5,  1, 1, 0, 1, 8'h2E};

        rst = 1'b1; clear = 1'b0; payload_valid = 1'b0; payload_last = 1'b0;
        payload_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_data", o_rd[0], 0);
        check("reset buffer_length", o_len[0], 0);
        check("reset done", o_dn[0], 0);
        check("reset ready", o_rdy[0], 1);
        rst = 1'b0;

        // Read-back of a stored payload.
        s = "12 -3 45\n";
        send_packet(s, 9, 1'b1);
        for (int a = 0; a < 8; a++) begin
            read_check($sformatf("readback[%0d]", a), 0, a, s[8*(8-a) +: 8]);
        end

        for (int unsigned v = 0; v < NVEC; v++) begin
            int k;
            k = vecs[v].inst;
            do_clear();
            send_packet(vecs[v].data, vecs[v].n, 1'b1);
            check($sformatf("v%0d done", v), o_dn[k], 1);
            check($sformatf("v%0d ready", v), o_rdy[k], 0);
            check($sformatf("v%0d buffer_length", v), o_len[k], vecs[v].exp_len);
            check($sformatf("v%0d token_count", v), o_tok[k], vecs[v].exp_tok);
            check($sformatf("v%0d invalid", v), o_inv[k], vecs[v].exp_inv);
            check($sformatf("v%0d overflow", v), o_ov[k], vecs[v].exp_ov);
            check($sformatf("v%0d err_index", v), o_eix[k], vecs[v].exp_eix);
            check($sformatf("v%0d err_char", v), o_ech[k], vecs[v].exp_ech);
        end

        // Stored newline becomes a space.
        do_clear();
        s = "1\r\n2";
        send_packet(s, 4, 1'b1);
        read_check("nl_sep addr1", 2, 1, 8'h20);
        read_check("nl_sep addr3", 2, 3, 8'h32);

        // Clear mid-packet with a concurrent beat; that beat is dropped.
        do_clear();
        s = "5 6";
        send_packet(s, 3, 1'b0);
        check("pre-clear length", o_len[0], 3);
        payload_data = 8'h39; payload_valid = 1'b1; payload_last = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; payload_valid = 1'b0;
        check("clear length", o_len[0], 0);
        check("clear tokens", o_tok[0], 0);
        check("clear done", o_dn[0], 0);
        check("clear rd_data", o_rd[0], 0);
        s = "8";
        send_packet(s, 1, 1'b1);
        check("post-clear length", o_len[0], 1);
        check("post-clear tokens", o_tok[0], 1);
        check("post-clear done", o_dn[0], 1);
        read_check("post-clear addr0", 0, 0, 8'h38);

        // Beats offered while done are refused.
        s = "99";
        send_packet(s, 2, 1'b1);
        check("done holds length", o_len[0], 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
